ram_arbiter: RTL

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/ram_arbiter.sv
// Two-requester arbiter in front of a single-port RAM: bounded-burst ownership,
// combinational RAM drive, and one-cycle-later read-data return to the issuing requester.
module ram_arbiter #(
   parameter int unsigned MAX_BURST = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        a_req,
   input  logic        a_we,
   input  logic [9:0]  a_addr,
   input  logic [7:0]  a_wdata,
   output logic        a_gnt,
   output logic        a_rvalid,
   output logic [7:0]  a_rdata,
   input  logic        b_req,
   input  logic        b_we,
   input  logic [9:0]  b_addr,
   input  logic [7:0]  b_wdata,
   output logic        b_gnt,
   output logic        b_rvalid,
   output logic [7:0]  b_rdata,
   output logic        ram_en,
   output logic        ram_we,
   output logic [9:0]  ram_addr,
   output logic [7:0]  ram_data,
   input  logic [7:0]  ram_dout
);

   localparam int unsigned CW = 3;
   localparam logic LAST_A = 1'b0;
   localparam logic LAST_B = 1'b1;

   typedef enum logic [1:0] {IDLE = 2'd0, OWN_A = 2'd1, OWN_B = 2'd2} state_e;

   state_e          cur_q, cur_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            last_q, last_d;
   logic            a_rvalid_q, a_rvalid_d;
   logic            b_rvalid_q, b_rvalid_d;
   logic            win_a, win_b;
   logic            under_burst;
   logic [CW-1:0]   cnt_inc;

   assign under_burst = (cnt_q < CW'(MAX_BURST));
   assign cnt_inc     = (cnt_q == CW'(7)) ? CW'(7) : cnt_q + CW'(1);

   // State register; reset leaves last pointing at B so A wins the first tie
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur_q      <= IDLE;
         cnt_q      <= '0;
         last_q     <= LAST_B;
         a_rvalid_q <= 1'b0;
         b_rvalid_q <= 1'b0;
      end else begin
         cur_q      <= cur_d;
         cnt_q      <= cnt_d;
         last_q     <= last_d;
         a_rvalid_q <= a_rvalid_d;
         b_rvalid_q <= b_rvalid_d;
      end
   end

   // Winner selection, next state and combinational RAM drive
   always_comb begin
      win_a      = 1'b0;
      win_b      = 1'b0;
      cur_d      = cur_q;
      cnt_d      = cnt_q;
      last_d     = last_q;
      a_rvalid_d = 1'b0;
      b_rvalid_d = 1'b0;
      a_gnt      = 1'b0;
      b_gnt      = 1'b0;
      ram_en     = 1'b0;
      ram_we     = 1'b0;
      ram_addr   = '0;
      ram_data   = '0;

      if (!rst) begin
         case (cur_q)
            OWN_A: begin
               if (a_req && (under_burst || !b_req)) win_a = 1'b1;
               else if (b_req)                       win_b = 1'b1;
            end
            OWN_B: begin
               if (b_req && (under_burst || !a_req)) win_b = 1'b1;
               else if (a_req)                       win_a = 1'b1;
            end
            default: begin
               if (a_req && b_req) begin
                  win_a = (last_q == LAST_B);
                  win_b = (last_q == LAST_A);
               end else begin
                  win_a = a_req;
                  win_b = b_req;
               end
            end
         endcase
      end

      if (win_a) begin
         a_gnt      = 1'b1;
         ram_en     = 1'b1;
         ram_we     = a_we;
         ram_addr   = a_addr;
         ram_data   = a_wdata;
         a_rvalid_d = !a_we;
         cur_d      = OWN_A;
         last_d     = LAST_A;
         cnt_d      = (cur_q == OWN_A) ? cnt_inc : CW'(1);
      end else if (win_b) begin
         b_gnt      = 1'b1;
         ram_en     = 1'b1;
         ram_we     = b_we;
         ram_addr   = b_addr;
         ram_data   = b_wdata;
         b_rvalid_d = !b_we;
         cur_d      = OWN_B;
         last_d     = LAST_B;
         cnt_d      = (cur_q == OWN_B) ? cnt_inc : CW'(1);
      end else begin
         cur_d = IDLE;
         cnt_d = '0;
      end
   end

   assign a_rvalid = a_rvalid_q;
   assign b_rvalid = b_rvalid_q;
   assign a_rdata  = a_rvalid_q ? ram_dout : 8'h00;
   assign b_rdata  = b_rvalid_q ? ram_dout : 8'h00;

endmodule
